// File: rtl/proc_pkg.sv
// Shared constants for the multi-cycle processor control unit.
package proc_pkg;

  // Opcode encodings (IR[8:6]); 1xx is reserved and executes as a NOP
  localparam logic [2:0] OPC_MV  = 3'b000;
  localparam logic [2:0] OPC_MVI = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_SUB = 3'b011;

  // Instruction field positions within the 9-bit IR
  localparam int unsigned Y_LSB   = 0;
  localparam int unsigned X_LSB   = 3;
  localparam int unsigned OPC_LSB = 6;

  // Sequencer steps
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

endpackage

// File: rtl/tstep_counter.sv
// 2-bit step counter: async active-low clear, synchronous clear wins over enable.
module tstep_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [1:0] count
);

  logic [1:0] count_d;
  logic [1:0] count_q;

  // Next-count selection
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 2'd1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/proc_control.sv
// Multi-cycle control unit: fetches an instruction into IR, then steps T0..T3
// driving the datapath strobes and the register-select decoder inputs.
module proc_control
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned OPC_W     = 3,
  parameter int unsigned REG_SEL_W = 3
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Run,
  input  logic [DATA_W-1:0]    DIN,
  output logic                 IRin,
  output logic [REG_SEL_W-1:0] RinSel,
  output logic                 RinEn,
  output logic [REG_SEL_W-1:0] RoutSel,
  output logic                 RoutEn,
  output logic                 DINout,
  output logic                 Ain,
  output logic                 Gin,
  output logic                 Gout,
  output logic                 AddSub,
  output logic                 Done
);

  localparam int unsigned IR_W = OPC_W + 2 * REG_SEL_W;

  logic [IR_W-1:0]      ir_d;
  logic [IR_W-1:0]      ir_q;
  logic [1:0]           cnt;
  tstep_e               tstep;
  logic                 cnt_en;
  logic                 cnt_clr;
  logic                 abort;

  logic [OPC_W-1:0]     opc;
  logic [REG_SEL_W-1:0] fld_x;
  logic [REG_SEL_W-1:0] fld_y;
  logic                 is_arith;

  logic                 irin_c;
  logic [REG_SEL_W-1:0] rinsel_c;
  logic                 rinen_c;
  logic [REG_SEL_W-1:0] routsel_c;
  logic                 routen_c;
  logic                 dinout_c;
  logic                 ain_c;
  logic                 gin_c;
  logic                 gout_c;
  logic                 addsub_c;
  logic                 done_c;

  generate
    if (DATA_W > IR_W) begin : g_din_upper
      logic din_upper_unused;
      assign din_upper_unused = ^DIN[DATA_W-1:IR_W];
    end
  endgenerate

  tstep_counter u_tstep (
    .clk   (Clock),
    .rst_n (Resetn),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (cnt)
  );

  assign tstep    = tstep_e'(cnt);
  assign opc      = ir_q[OPC_LSB +: OPC_W];
  assign fld_x    = ir_q[X_LSB +: REG_SEL_W];
  assign fld_y    = ir_q[Y_LSB +: REG_SEL_W];
  assign is_arith = (opc == OPC_ADD) || (opc == OPC_SUB);

  // Step/opcode decode into strobes, IR next value and counter control
  always_comb begin
    ir_d      = ir_q;
    cnt_en    = 1'b0;
    abort     = 1'b0;
    irin_c    = 1'b0;
    rinsel_c  = '0;
    rinen_c   = 1'b0;
    routsel_c = '0;
    routen_c  = 1'b0;
    dinout_c  = 1'b0;
    ain_c     = 1'b0;
    gin_c     = 1'b0;
    gout_c    = 1'b0;
    addsub_c  = 1'b0;
    done_c    = 1'b0;
    case (tstep)
      T0: begin
        irin_c = Run;
        cnt_en = Run;
        if (Run) begin
          ir_d = DIN[IR_W-1:0];
        end
      end
      T1: begin
        case (opc)
          OPC_MV: begin
            routsel_c = fld_y;
            routen_c  = 1'b1;
            rinsel_c  = fld_x;
            rinen_c   = 1'b1;
            done_c    = 1'b1;
          end
          OPC_MVI: begin
            dinout_c = 1'b1;
            rinsel_c = fld_x;
            rinen_c  = 1'b1;
            done_c   = 1'b1;
          end
          OPC_ADD, OPC_SUB: begin
            routsel_c = fld_x;
            routen_c  = 1'b1;
            ain_c     = 1'b1;
            cnt_en    = 1'b1;
          end
          default: begin
            done_c = 1'b1;
          end
        endcase
      end
      T2: begin
        if (is_arith) begin
          routsel_c = fld_y;
          routen_c  = 1'b1;
          gin_c     = 1'b1;
          addsub_c  = opc[0];
          cnt_en    = 1'b1;
        end else begin
          abort = 1'b1;
        end
      end
      T3: begin
        if (is_arith) begin
          gout_c   = 1'b1;
          rinsel_c = fld_x;
          rinen_c  = 1'b1;
          done_c   = 1'b1;
        end else begin
          abort = 1'b1;
        end
      end
      default: begin
        abort = 1'b1;
      end
    endcase
    cnt_clr = done_c | abort;
  end

  // Instruction register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ir_q <= '0;
    end else begin
      ir_q <= ir_d;
    end
  end

  // Outputs are forced low while reset is asserted (asynchronously)
  always_comb begin
    IRin    = irin_c   & Resetn;
    RinEn   = rinen_c  & Resetn;
    RoutEn  = routen_c & Resetn;
    RinSel  = (Resetn && rinen_c)  ? rinsel_c  : '0;
    RoutSel = (Resetn && routen_c) ? routsel_c : '0;
    DINout  = dinout_c & Resetn;
    Ain     = ain_c    & Resetn;
    Gin     = gin_c    & Resetn;
    Gout    = gout_c   & Resetn;
    AddSub  = addsub_c & Resetn;
    Done    = done_c   & Resetn;
  end

endmodule
